// File: rtl/func4_pkg.sv
// Shared definitions for the func4 classifier checker: golden masks,
// code width and checker state encoding.
package func4_pkg;

   localparam int unsigned CODE_W = 4;

   // Bit n holds the golden output for input code n.
   localparam logic [15:0] PRIME_MASK = 16'h28AC;
   localparam logic [15:0] DIV3_MASK  = 16'h9249;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/func4_checker_if.sv
// Stimulus/response link between the checker (master) and the func4
// classifier under test (slave).
interface func4_checker_if;
   import func4_pkg::*;

   logic [CODE_W-1:0] a_out;
   logic              p_in;
   logic              d_in;

   modport master (output a_out, input p_in, input d_in);
   modport slave  (input a_out, output p_in, output d_in);

endinterface

// File: rtl/func4_golden.sv
// Combinational golden lookup: code -> expected {prime, divisible-by-3}.
module func4_golden
   import func4_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic              p_exp,
   output logic              d_exp
);

   // Index the golden masks by the current code.
   always_comb begin
      p_exp = PRIME_MASK[code];
      d_exp = DIV3_MASK[code];
   end

endmodule

// File: rtl/func4_checker.sv
// Self-checking sweeper for the func4 classifier: drives all 16 codes,
// samples p/d after a settle period and accumulates pass/fail results.
module func4_checker
   import func4_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   func4_checker_if.master   bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [4:0]        err_count,
   output logic              first_fail_valid,
   output logic [CODE_W-1:0] first_fail_code
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t            state;
   logic [3:0]        settle_cnt;
   logic [CODE_W-1:0] code;
   logic              p_exp;
   logic              d_exp;
   logic              mismatch;
   logic [4:0]        err_next;

   func4_golden u_golden (
      .code  (code),
      .p_exp (p_exp),
      .d_exp (d_exp)
   );

   assign bus.a_out = code;

   // Compare the sampled classifier outputs with the golden values; a miss
   // on either bit counts once for the code.
   always_comb begin
      mismatch = (bus.p_in != p_exp) || (bus.d_in != d_exp);
      err_next = err_count + 5'(mismatch);
   end

   // Sweep FSM with registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         settle_cnt       <= '0;
         code             <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_code  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  err_count        <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_code  <= '0;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  code             <= '0;
                  settle_cnt       <= '0;
                  busy             <= 1'b1;
                  state            <= DRIVE;
               end
            end
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_next;
                  if (!first_fail_valid) begin
                     first_fail_code  <= code;
                     first_fail_valid <= 1'b1;
                  end
               end
               // Pass uses err_next so the final code's result is included.
               if (code == '1) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  code       <= code + 4'd1;
                  settle_cnt <= '0;
                  state      <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/func4_checker.md
Name: func4_checker

Overview:
- Hardware self-checking driver/responder for the 4-bit func4 classifier.
- Sweeps all 16 input codes into the classifier and samples its p (prime) and d (divisible-by-3) outputs.
- Compares each sample against golden values and reports pass/fail, error count and first failing code.
- Used as on-chip BIST around func4, and as the checking end of the func4 stimulus interface in benches.

Parameters:
- SETTLE_CYCLES, 1, cycles each code is held on a_out before p_in/d_in are sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE
- a_out  output  4  code driven to the classifier's a input
- p_in  input  1  classifier p output (1 = code is prime)
- d_in  input  1  classifier d output (1 = code is divisible by 3)
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep completion until the next accepted start or reset
- pass  output  1  valid while done is high; 1 iff err_count == 0
- err_count  output  5  number of mismatching codes in the last sweep, range 0..16
- first_fail_valid  output  1  at least one mismatch has been recorded this sweep
- first_fail_code  output  4  code of the first mismatch; meaningful only when first_fail_valid is high

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: a_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_code=0, state=IDLE.
- Reset mid-sweep: all outputs take their reset values at that edge, and any sweep in progress is abandoned.
- Golden values: p=1 for codes {2,3,5,7,11,13}. d=1 for codes {0,3,6,9,12,15}; 0 counts as divisible by 3.
- State machine: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, on the edge where start=1:
  - clear err_count, first_fail_valid, first_fail_code, done and pass;
  - set a_out=0, settle counter=0, busy=1;
  - go to DRIVE.
- DRIVE: hold a_out for exactly SETTLE_CYCLES edges (counter 0..SETTLE_CYCLES-1), then go to SAMPLE.
- SAMPLE (1 cycle):
  - compare p_in and d_in with golden(a_out); a mismatch on either bit counts as one error for that code;
  - on a mismatch, err_count += 1; if first_fail_valid=0, also set first_fail_code=a_out and first_fail_valid=1;
  - if a_out==15: go to DONE, busy=0, done=1, and set pass from the error count that includes this final comparison;
  - otherwise: a_out += 1, clear the settle counter, go to DRIVE.
- Timing:
  - each code occupies SETTLE_CYCLES+1 edges;
  - done rises exactly 16*(SETTLE_CYCLES+1) edges after the edge that accepted start.
- DONE:
  - outputs hold and a_out stays at 15;
  - start=1 clears results and restarts exactly as from IDLE.
- start while busy: ignored, with no effect on the sweep.
- a_out wrap: never wraps inside a sweep. The increment happens only for codes below 15.
- err_count: cannot overflow, since there is at most one error per code and 5 bits hold 16.
- p_in/d_in: sampled only in SAMPLE; values in other states are don't-care.

Decomposition:
- Package func4_pkg:
  - PRIME_MASK = 16'h28AC;
  - DIV3_MASK = 16'h9249 (bit n = golden value for code n);
  - CODE_W = 4;
  - state enum {IDLE, DRIVE, SAMPLE, DONE}.
- One sub-module, func4_golden: combinational lookup code -> {p_exp, d_exp} indexed into the masks. It is shared with future func4 benches.

Test Plan:
1. SETTLE_CYCLES=1, correct func4 model attached, start after reset -> a_out steps 0..15, each held 2 cycles; done at edge 32; pass=1; err_count=0; first_fail_valid=0.
2. p_in forced to 0 -> err_count=6, first_fail_code=2, first_fail_valid=1, pass=0.
3. d_in forced to 1 -> err_count=10, first_fail_code=1, pass=0.
4. p_in and d_in both inverted relative to the correct model -> err_count=16, first_fail_code=0, pass=0.
5. reset pulsed while a_out=7 -> next edge has all outputs at reset values. Then:
   - start pulsed at a_out=4 of a new sweep -> ignored;
   - start pulsed in DONE -> results cleared and a fresh sweep from 0.
6. SETTLE_CYCLES=3 with the correct model -> each code held 4 cycles; done at edge 64; pass=1.
